fifo_drain_ctrl: RTL and testbench

// - Read-side master for SYN_FIFO-class buffers. On start, drains exactly burst_len words from the FIFO.
// - Presents the words on a valid/ready stream to the downstream consumer.
// - Hides the 1-cycle FIFO read latency with a 2-entry skid buffer, so throughput is 1 word/clk while m_ready stays high.
// - Sits between the 128-bit FIFO and the egress datapath.

---
 rtl/fifo_drain_ctrl_pkg.sv | 6 +
 rtl/fifo_drain_skid.sv | 28 ++
 rtl/fifo_drain_ctrl.sv | 85 ++++++++
 tb/tb_fifo_drain_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_ctrl_pkg.sv
// fifo_pkg: shared widths and drain FSM state type for SYN_FIFO-side blocks
package fifo_pkg;
  localparam int FIFO_WIDTH = 128;
  localparam int LEN_W = 16;
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} drain_state_t;
endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: 2-entry valid/ready skid buffer, head entry drives the output
module fifo_drain_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] tail_data;
  // shift the tail forward on pop and write a pushed word into the first free slot
  always_ff @(posedge clk)
    if (!rst) begin
      cnt       <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      if (pop) head_data <= (cnt == 2'd2) ? tail_data : push_data;
      else if (push && cnt == 2'd0) head_data <= push_data;
      if (push && (pop ? cnt == 2'd2 : cnt == 2'd1)) tail_data <= push_data;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains burst_len words from a 1-cycle-latency FIFO onto a valid/ready stream
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int LEN_W  = fifo_pkg::LEN_W,
  parameter int SKID_D = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_out
);
  drain_state_t     state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic [2:0]       occ;
  assign pop = m_valid & m_ready;
  // occupancy after this cycle's pop; also the buffer count on the next cycle
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = rst & (state == DRAIN) & !abort & !fifo_empty & (issued != len_q) & (occ < 3'(SKID_D));
  fifo_drain_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head_data (m_data),
    .cnt       (buf_cnt)
  );
  // burst FSM, read-latency tracking, counters and registered status outputs
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
      words_out <= '0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      inflight  <= fifo_rd_en;
      m_valid   <= occ != 3'd0;
      issued    <= issued + LEN_W'(fifo_rd_en);
      words_out <= words_out + LEN_W'(pop);
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_q     <= burst_len;
          issued    <= '0;
          words_out <= '0;
          aborted   <= 1'b0;
          state     <= (burst_len == '0) ? DONE : DRAIN;
          busy      <= burst_len != '0;
          done      <= burst_len == '0;
        end
        DRAIN: if (abort || issued == len_q) begin
          state   <= FLUSH;
          aborted <= issued != len_q;
        end
        FLUSH: if (!inflight && buf_cnt == 2'd0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: scoreboard bench for the FIFO drain controller
module tb_fifo_drain_ctrl;
  localparam int W = fifo_pkg::FIFO_WIDTH;
  localparam int LW = fifo_pkg::LEN_W;
  logic clk = 0, rst = 0, start = 0, abort = 0, m_ready = 0, fifo_empty = 1;
  logic [LW-1:0] burst_len = '0;
  logic [W-1:0] fifo_rd_data = '0;
  logic fifo_rd_en, m_valid, busy, done, aborted;
  logic [W-1:0] m_data;
  logic [LW-1:0] words_out;
  fifo_drain_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .done(done), .aborted(aborted), .words_out(words_out)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, seq = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic rd_s = 0;
  int deliv = 0, n_iss = 0, len_m = 0;
  bit drain_m = 0, ab_m = 0, hold_p = 0, prev_done = 0;
  logic [W-1:0] data_p = '0;
  int start_cyc = 0, first_rd = -1, first_mv = -1, rd_run = 0, rd_run_max = 0, mv_run = 0, mv_run_max = 0;
  int done_cyc = -1, done_words = -1, done_iss = -1;
  bit done_ab = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word();
    logic [W-1:0] d = {$urandom(), $urandom(), $urandom(), 32'(seq)};
    seq++;
    fq.push_back(d);
    fifo_empty = 0;
  endtask

  task automatic clear_fifo();
    fq.delete();
    fifo_empty = 1;
  endtask

  // FIFO model: a read sampled in one cycle presents its word for the following cycle
  always @(posedge clk) begin
    #1;
    if (rd_s && fq.size() != 0) begin
      fifo_rd_data = fq.pop_front();
      exp_q.push_back(fifo_rd_data);
    end
    fifo_empty = fq.size() == 0;
  end

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      deliv = 0;
      n_iss = 0;
      len_m = 0;
      drain_m = 0;
      ab_m = 0;
    end else begin
      chk("words_out", words_out, deliv);
      if (fifo_empty) chk("rd_while_empty", fifo_rd_en, 0);
      if (hold_p) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, data_p);
      end
      if (drain_m || n_iss != deliv) chk("busy_active", busy, 1);
      if (fifo_rd_en) begin
        n_iss++;
        rd_run++;
        if (first_rd < 0) first_rd = cyc - start_cyc;
      end else rd_run = 0;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
      if (m_valid) begin
        mv_run++;
        if (first_mv < 0) first_mv = cyc - start_cyc;
      end else mv_run = 0;
      if (mv_run > mv_run_max) mv_run_max = mv_run;
      if (m_valid && m_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("word_order", m_data, exp_q.pop_front());
        deliv++;
      end
      chk("outstanding_le2", (n_iss - deliv) <= 2, 1);
      chk("issue_le_len", n_iss <= len_m, 1);
      if (drain_m) begin
        if (abort && n_iss < len_m) begin
          ab_m = 1;
          drain_m = 0;
        end else if (n_iss == len_m) drain_m = 0;
      end
      if (done) begin
        chk("done_drained", n_iss - deliv, 0);
        chk("done_aborted", aborted, ab_m);
        if (!ab_m) chk("done_count", deliv, len_m);
        chk("done_single", prev_done, 0);
        chk("done_busy", busy, 0);
        done_cyc = cyc - start_cyc;
        done_words = int'(words_out);
        done_iss = n_iss;
        done_ab = aborted;
      end
      if (start) begin
        len_m = int'(burst_len);
        deliv = 0;
        n_iss = 0;
        drain_m = burst_len != 0;
        ab_m = 0;
        start_cyc = cyc;
        first_rd = -1;
        first_mv = -1;
        rd_run_max = 0;
        mv_run_max = 0;
        done_cyc = -1;
        done_words = -1;
        done_iss = -1;
      end
    end
    prev_done = rst && done;
    hold_p = rst && m_valid && !m_ready;
    data_p = m_data;
    rd_s = fifo_rd_en;
  end

  task automatic wait_done(input int mode, input int refill, input int refill_at, input int abort_div);
    int n = 0;
    int left = refill;
    while (!done && n < 500) begin
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~m_ready : 1'($urandom_range(0, 1));
      if (refill_at == n) begin
        repeat (left) push_word();
        left = 0;
      end else if (refill_at < 0 && left > 0 && $urandom_range(0, 1) == 1) begin
        push_word();
        left--;
      end
      if (abort_div > 0 && $urandom_range(0, abort_div - 1) == 0) abort = 1;
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    abort = 0;
    tick();
  endtask

  task automatic begin_burst(input int len);
    burst_len = LW'(len);
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_words_out", words_out, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst = 1;
    tick();
    // 4 words, m_ready held high
    repeat (4) push_word();
    m_ready = 1;
    begin_burst(4);
    wait_done(0, 0, -1, 0);
    chk("t1_first_rd", first_rd, 1);
    chk("t1_rd_run", rd_run_max, 4);
    chk("t1_first_mv", first_mv, 3);
    chk("t1_mv_run", mv_run_max, 4);
    chk("t1_done_cyc", done_cyc, 8);
    chk("t1_words", done_words, 4);
    chk("t1_aborted", done_ab, 0);
    chk("t1_words_hold", words_out, 4);
    // zero-length burst with data waiting in the FIFO
    repeat (2) push_word();
    begin_burst(0);
    wait_done(0, 0, -1, 0);
    chk("t0_done_cyc", done_cyc, 1);
    chk("t0_no_rd", first_rd, -1);
    chk("t0_no_valid", first_mv, -1);
    chk("t0_words", done_words, 0);
    // 8 words with m_ready toggling
    clear_fifo();
    repeat (8) push_word();
    m_ready = 0;
    begin_burst(8);
    wait_done(1, 0, -1, 0);
    chk("t2_words", done_words, 8);
    chk("t2_aborted", done_ab, 0);
    // FIFO runs dry after 3 words, refilled 5 clocks later
    clear_fifo();
    repeat (3) push_word();
    begin_burst(10);
    wait_done(0, 7, 5, 0);
    chk("t3_words", done_words, 10);
    chk("t3_aborted", done_ab, 0);
    // abort once 3 reads were issued, with the consumer stalled
    clear_fifo();
    repeat (10) push_word();
    m_ready = 1;
    begin_burst(10);
    for (int i = 0; i < 50 && n_iss < 3; i++) tick();
    chk("t4_iss_reached", n_iss, 3);
    abort = 1;
    m_ready = 0;
    repeat (5) tick();
    chk("t4_no_more_rd", n_iss, 3);
    abort = 1;
    m_ready = 1;
    for (int i = 0; i < 50 && !done; i++) tick();
    chk("t4_done_seen", done, 1);
    abort = 0;
    tick();
    chk("t4_words", done_words, 3);
    chk("t4_iss", done_iss, 3);
    chk("t4_aborted", done_ab, 1);
    // reset mid-burst while the skid buffer is full
    clear_fifo();
    repeat (10) push_word();
    m_ready = 0;
    begin_burst(10);
    repeat (6) tick();
    chk("t5_full_valid", m_valid, 1);
    rst = 0;
    tick();
    rst = 1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd_en", fifo_rd_en, 0);
    tick();
    m_ready = 1;
    begin_burst(5);
    wait_done(0, 0, -1, 0);
    chk("t5_words", done_words, 5);
    chk("t5_aborted", done_ab, 0);
    // randomized bursts, stalls, refills and aborts
    for (int b = 0; b < 40; b++) begin
      int len = $urandom_range(0, 12);
      int pre = $urandom_range(0, len);
      repeat (pre) push_word();
      begin_burst(len);
      wait_done(2, len - pre, -1, ($urandom_range(0, 2) == 0) ? 12 : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
